// File: rtl/vdf_iteration_ctrl.sv
// VDF iteration controller: issues x to a pipelined modular squarer, counts T squarings, returns y.
// Optional stall watchdog is compiled in when VDF_ITER_WATCHDOG_EN is defined.
module vdf_iteration_ctrl #(
    parameter int MOD_LEN      = 1024,
    parameter int WORD_LEN     = 16,
    parameter int NUM_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int SQ_OUT_BITS  = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int ITER_W       = 64,
    parameter int WDOG_CYCLES  = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [MOD_LEN-1:0]     job_x,
    input  logic [ITER_W-1:0]      job_t,
    output logic                   sq_start,
    output logic [MOD_LEN-1:0]     sq_in,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    input  logic                   sq_valid,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [MOD_LEN-1:0]     result_y,
    output logic [ITER_W-1:0]      result_t,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [MOD_LEN-1:0] y_reg;
    logic [MOD_LEN-1:0] packed_y;
    logic [ITER_W-1:0]  t_reg;
    logic [ITER_W-1:0]  iter_cnt;
    logic               upper_nz;
    logic               accept;
    logic               capture;
    logic               last_pulse;
    logic               wdog_fire;

    // Each squarer field is double width; keep the low half, flag any carry left in the high half.
    always_comb begin
        packed_y = '0;
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            packed_y[j*WORD_LEN +: WORD_LEN] = sq_out[j*2*WORD_LEN +: WORD_LEN];
            upper_nz = upper_nz | (|sq_out[j*2*WORD_LEN + WORD_LEN +: WORD_LEN]);
        end
    end

    assign accept     = (state == IDLE) && job_valid;
    assign capture    = (state == RUN) && sq_valid;
    assign last_pulse = capture && ((iter_cnt + ITER_W'(1)) == t_reg);

`ifdef VDF_ITER_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_cnt <= '0;
        end else if (sq_start || capture) begin
            wdog_cnt <= '0;
        end else if (state == RUN) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    assign wdog_fire = (state == RUN) && !sq_valid && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        job_ready    = 1'b0;
        sq_start     = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    state_next = (job_t == '0) ? DONE : START;
                end
            end
            START: begin
                sq_start   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (last_pulse || wdog_fire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // x seeds both the squarer operand and the running value so T==0 returns x unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sq_in    <= '0;
            y_reg    <= '0;
            t_reg    <= '0;
            iter_cnt <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            sq_in    <= job_x;
            y_reg    <= job_x;
            t_reg    <= job_t;
            iter_cnt <= '0;
            err      <= 1'b0;
        end else if (capture) begin
            iter_cnt <= iter_cnt + ITER_W'(1);
            y_reg    <= packed_y;
            if (upper_nz) begin
                err <= 1'b1;
            end
        end else if (wdog_fire) begin
            err <= 1'b1;
        end
    end

    assign result_y = y_reg;
    assign result_t = iter_cnt;

endmodule
